// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, mstatus and
// mip bit positions, write-operation and control-state encodings, and the
// csrs_t snapshot structure exported by csr_unit.
package csr_unit_pkg;

  // Snapshot field width and upper bound on hardware performance counters
  localparam int unsigned CSR_W    = 64;
  localparam int unsigned NCNT_MAX = 8;
  localparam int unsigned HPM_IW   = $clog2(NCNT_MAX);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPM_BASE = 12'hB03;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  typedef enum logic [1:0] {
    WR_WRITE = 2'b00,
    WR_SET   = 2'b01,
    WR_CLEAR = 2'b10,
    WR_NOP   = 2'b11
  } wr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } ctrl_state_e;

  // Live register snapshot; narrower datapaths are zero-extended into it
  typedef struct packed {
    logic [1:0]                       mode;
    logic [CSR_W-1:0]                 mstatus;
    logic [CSR_W-1:0]                 mie;
    logic [CSR_W-1:0]                 mtvec;
    logic [CSR_W-1:0]                 mscratch;
    logic [CSR_W-1:0]                 mepc;
    logic [CSR_W-1:0]                 mcause;
    logic [CSR_W-1:0]                 mtval;
    logic [CSR_W-1:0]                 mip;
    logic [CSR_W-1:0]                 mcycle;
    logic [CSR_W-1:0]                 minstret;
    logic [NCNT_MAX-1:0][CSR_W-1:0]   mhpmcounter;
  } csrs_t;

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with synchronous load; a load wins over an increment.
// Ports: clk, rst_n (async active-low), inc_i, load_en_i, load_val_i, cnt_o.
module csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         load_en_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, else increment (wraps naturally), else hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_en_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: combinational CSR read port, write/set/clear port,
// trap entry and mret sequencing with a one-cycle PC redirect, interrupt
// pending detection, and cycle/instret/hpm counters.
// Ports: clk, reset (async active-low); rd_addr/rd_data/rd_illegal read port;
// wr_en/wr_op/wr_addr/wr_data write port; trap_* and mret_req control inputs;
// instret, hpm_event counter events; irq_timer/irq_ext interrupt levels;
// redirect_valid/redirect_pc, irq_pending and the csrGroup snapshot outputs.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     NCNT        = 2,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic            wr_en,
  input  logic [1:0]      wr_op,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic            instret,
  input  logic [NCNT-1:0] hpm_event,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_pending,
  output csrs_t           csrGroup
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [1:0]      mode_q, mode_d;
  logic            irq_timer_q, irq_ext_q;

  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] mcycle_val;
  logic [XLEN-1:0] minstret_val;
  logic [XLEN-1:0] hpm_cnt [NCNT_MAX];

  logic [XLEN:0]   rd_lookup;
  logic [XLEN:0]   wr_lookup;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_new;
  logic            wr_accept;
  logic [XLEN-1:0] tvec_base;

  // Only the timer and external interrupt bits of mip are implemented
  always_comb begin
    mip_val           = '0;
    mip_val[MIP_MTIP] = irq_timer_q;
    mip_val[MIP_MEIP] = irq_ext_q;
  end

  // Address decode shared by the read port and the read-modify-write path;
  // bit XLEN flags an unimplemented address
  function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
    logic [XLEN:0] r;
    r = '0;
    case (addr)
      CSR_MSTATUS:  r[XLEN-1:0] = mstatus_q;
      CSR_MIE:      r[XLEN-1:0] = mie_q;
      CSR_MTVEC:    r[XLEN-1:0] = mtvec_q;
      CSR_MSCRATCH: r[XLEN-1:0] = mscratch_q;
      CSR_MEPC:     r[XLEN-1:0] = mepc_q;
      CSR_MCAUSE:   r[XLEN-1:0] = mcause_q;
      CSR_MTVAL:    r[XLEN-1:0] = mtval_q;
      CSR_MIP:      r[XLEN-1:0] = mip_val;
      CSR_MCYCLE:   r[XLEN-1:0] = mcycle_val;
      CSR_MINSTRET: r[XLEN-1:0] = minstret_val;
      CSR_MHARTID:  r           = '0;
      default: begin
        r[XLEN] = 1'b1;
        for (int unsigned i = 0; i < NCNT; i++) begin
          if (addr == CSR_MHPM_BASE + 12'(i)) begin
            r = {1'b0, hpm_cnt[HPM_IW'(i)]};
          end
        end
      end
    endcase
    return r;
  endfunction

  always_comb begin
    rd_lookup = csr_lookup(rd_addr);
    wr_lookup = csr_lookup(wr_addr);
  end

  assign rd_data    = rd_lookup[XLEN-1:0];
  assign rd_illegal = rd_lookup[XLEN];
  assign wr_old     = wr_lookup[XLEN-1:0];

  // Read-modify-write operand
  always_comb begin
    wr_new = wr_old;
    case (wr_op)
      WR_WRITE: wr_new = wr_data;
      WR_SET:   wr_new = wr_old | wr_data;
      WR_CLEAR: wr_new = wr_old & ~wr_data;
      default:  wr_new = wr_old;
    endcase
  end

  // A write lands only in IDLE and only when no trap or mret claims the cycle
  assign wr_accept = (state_q == ST_IDLE) && !trap_req && !mret_req &&
                     wr_en && (wr_op != WR_NOP);

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (1'b1),
    .load_en_i  (wr_accept && (wr_addr == CSR_MCYCLE)),
    .load_val_i (wr_new),
    .cnt_o      (mcycle_val)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (instret),
    .load_en_i  (wr_accept && (wr_addr == CSR_MINSTRET)),
    .load_val_i (wr_new),
    .cnt_o      (minstret_val)
  );

  for (genvar g = 0; g < NCNT_MAX; g++) begin : g_hpm
    if (g < NCNT) begin : g_on
      csr_counter #(.W(XLEN)) u_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .inc_i      (hpm_event[g]),
        .load_en_i  (wr_accept && (wr_addr == CSR_MHPM_BASE + 12'(g))),
        .load_val_i (wr_new),
        .cnt_o      (hpm_cnt[g])
      );
    end else begin : g_off
      assign hpm_cnt[g] = '0;
    end
  end

  // Control FSM and CSR next-state: trap > mret > write, IDLE only
  always_comb begin
    state_d    = state_q;
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mode_d     = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_req) begin
          mepc_d                                 = trap_pc;
          mcause_d                               = trap_cause;
          mtval_d                                = trap_tval;
          mstatus_d[MSTATUS_MPIE]                = mstatus_q[MSTATUS_MIE];
          mstatus_d[MSTATUS_MIE]                 = 1'b0;
          mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mode_q;
          mode_d                                 = 2'b11;
          state_d                                = ST_TRAP;
        end else if (mret_req) begin
          mstatus_d[MSTATUS_MIE]                 = mstatus_q[MSTATUS_MPIE];
          mstatus_d[MSTATUS_MPIE]                = 1'b1;
          mode_d                                 = mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
          state_d                                = ST_RET;
        end else if (wr_accept) begin
          case (wr_addr)
            CSR_MSTATUS:  mstatus_d  = wr_new;
            CSR_MIE:      mie_d      = wr_new;
            CSR_MTVEC:    mtvec_d    = wr_new & ~XLEN'(2);
            CSR_MSCRATCH: mscratch_d = wr_new;
            CSR_MEPC:     mepc_d     = wr_new & ~XLEN'(3);
            CSR_MCAUSE:   mcause_d   = wr_new;
            CSR_MTVAL:    mtval_d    = wr_new;
            default:      ;
          endcase
        end
      end
      ST_TRAP: state_d = ST_IDLE;
      ST_RET:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mstatus_q   <= '0;
      mie_q       <= '0;
      mtvec_q     <= MTVEC_RESET;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mode_q      <= 2'b11;
      irq_timer_q <= 1'b0;
      irq_ext_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mstatus_q   <= mstatus_d;
      mie_q       <= mie_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mode_q      <= mode_d;
      irq_timer_q <= irq_timer;
      irq_ext_q   <= irq_ext;
    end
  end

  // Redirect is decoded from the state flop so reset clears it asynchronously;
  // mtvec, mcause and mepc are frozen while TRAP/RET is active
  assign tvec_base = mtvec_q & ~XLEN'(3);

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      ST_TRAP: begin
        redirect_valid = 1'b1;
        if (mtvec_q[0] && mcause_q[XLEN-1]) begin
          redirect_pc = tvec_base + (XLEN'(mcause_q[XLEN-2:0]) << 2);
        end else begin
          redirect_pc = tvec_base;
        end
      end
      ST_RET: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc_q;
      end
      default: ;
    endcase
  end

  assign irq_pending = mstatus_q[MSTATUS_MIE] & (|(mip_val & mie_q));

  always_comb begin
    csrGroup          = '0;
    csrGroup.mode     = mode_q;
    csrGroup.mstatus  = CSR_W'(mstatus_q);
    csrGroup.mie      = CSR_W'(mie_q);
    csrGroup.mtvec    = CSR_W'(mtvec_q);
    csrGroup.mscratch = CSR_W'(mscratch_q);
    csrGroup.mepc     = CSR_W'(mepc_q);
    csrGroup.mcause   = CSR_W'(mcause_q);
    csrGroup.mtval    = CSR_W'(mtval_q);
    csrGroup.mip      = CSR_W'(mip_val);
    csrGroup.mcycle   = CSR_W'(mcycle_val);
    csrGroup.minstret = CSR_W'(minstret_val);
    for (int unsigned i = 0; i < NCNT_MAX; i++) begin
      csrGroup.mhpmcounter[HPM_IW'(i)] = CSR_W'(hpm_cnt[HPM_IW'(i)]);
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_csr_unit;
  import csr_unit_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NCNT = 2;
  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0100;

  logic            clk = 1'b0;
  logic            reset;
  logic [11:0]     rd_addr;
  logic [63:0]     rd_data;
  logic            rd_illegal;
  logic            wr_en;
  logic [1:0]      wr_op;
  logic [11:0]     wr_addr;
  logic [63:0]     wr_data;
  logic            trap_req;
  logic [63:0]     trap_cause, trap_pc, trap_tval;
  logic            mret_req;
  logic            instret;
  logic [NCNT-1:0] hpm_event;
  logic            irq_timer, irq_ext;
  logic            redirect_valid;
  logic [63:0]     redirect_pc;
  logic            irq_pending;
  csrs_t           csr_group;

  csr_unit #(.XLEN(XLEN), .NCNT(NCNT), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
    .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .instret(instret), .hpm_event(hpm_event),
    .irq_timer(irq_timer), .irq_ext(irq_ext),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq_pending(irq_pending), .csrGroup(csr_group)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: architectural state plus which redirect (if any) is shown
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;
  logic [63:0] m_hpm [NCNT];
  logic [1:0]  m_mode;
  logic        m_it, m_ie;
  int          m_phase;   // 0 none, 1 trap redirect, 2 return redirect

  task automatic model_reset();
    m_mstatus = '0; m_mie = '0; m_mtvec = MTVEC_RST; m_mscratch = '0;
    m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mcycle = '0; m_minstret = '0;
    for (int i = 0; i < NCNT; i++) m_hpm[i] = '0;
    m_mode = 2'd3; m_it = 1'b0; m_ie = 1'b0; m_phase = 0;
  endtask

  function automatic logic [63:0] m_mip();
    return (64'(m_it) << 7) | (64'(m_ie) << 11);
  endfunction

  function automatic logic [64:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h343: return {1'b0, m_mtval};
      12'h344: return {1'b0, m_mip()};
      12'hB00: return {1'b0, m_mcycle};
      12'hB02: return {1'b0, m_minstret};
      12'hB03: return {1'b0, m_hpm[0]};
      12'hB04: return {1'b0, m_hpm[1]};
      12'hF14: return 65'd0;
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  function automatic logic [63:0] m_redirect();
    logic [63:0] base;
    base = m_mtvec & ~64'h3;
    if (m_phase == 1) begin
      if (m_mtvec[0] && m_mcause[63]) return base + 64'd4 * {1'b0, m_mcause[62:0]};
      return base;
    end
    if (m_phase == 2) return m_mepc;
    return 64'd0;
  endfunction

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_step();
    logic [63:0] old, nv, st;
    logic [64:0] rv;
    if (!reset) return;
    rv  = m_read(wr_addr);
    old = rv[63:0];
    case (wr_op)
      2'b00:   nv = wr_data;
      2'b01:   nv = old | wr_data;
      2'b10:   nv = old & ~wr_data;
      default: nv = old;
    endcase
    m_it = irq_timer;
    m_ie = irq_ext;
    m_mcycle = m_mcycle + 64'd1;
    if (instret) m_minstret = m_minstret + 64'd1;
    for (int i = 0; i < NCNT; i++) if (hpm_event[i]) m_hpm[i] = m_hpm[i] + 64'd1;
    if (m_phase != 0) begin
      m_phase = 0;
    end else if (trap_req) begin
      st = m_mstatus;
      st[7] = m_mstatus[3];
      st[3] = 1'b0;
      st[12:11] = m_mode;
      m_mstatus = st;
      m_mepc = trap_pc; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mode = 2'd3;
      m_phase = 1;
    end else if (mret_req) begin
      st = m_mstatus;
      st[3] = m_mstatus[7];
      st[7] = 1'b1;
      st[12:11] = 2'd0;
      m_mode = m_mstatus[12:11];
      m_mstatus = st;
      m_phase = 2;
    end else if (wr_en && wr_op != 2'b11) begin
      case (wr_addr)
        12'h300: m_mstatus  = nv;
        12'h304: m_mie      = nv;
        12'h305: m_mtvec    = nv & ~64'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~64'h3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        12'hB00: m_mcycle   = nv;
        12'hB02: m_minstret = nv;
        12'hB03: m_hpm[0]   = nv;
        12'hB04: m_hpm[1]   = nv;
        default: ;
      endcase
    end
  endtask

  // Compare all observable outputs against the model, reading CSR address a
  task automatic check_all(input logic [11:0] a);
    logic [64:0] rv;
    rd_addr = a;
    #1;
    rv = m_read(a);
    chk("rd_data", rd_data, rv[63:0]);
    chk("rd_illegal", 64'(rd_illegal), 64'(rv[64]));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_phase != 0));
    chk("redirect_pc", redirect_pc, m_redirect());
    chk("irq_pending", 64'(irq_pending), 64'(m_mstatus[3] && ((m_mip() & m_mie) != 0)));
    chk("grp_mstatus", csr_group.mstatus, m_mstatus);
    chk("grp_mtvec", csr_group.mtvec, m_mtvec);
    chk("grp_mepc", csr_group.mepc, m_mepc);
    chk("grp_mcause", csr_group.mcause, m_mcause);
    chk("grp_mscratch", csr_group.mscratch, m_mscratch);
    chk("grp_mcycle", csr_group.mcycle, m_mcycle);
    chk("grp_minstret", csr_group.minstret, m_minstret);
    chk("grp_hpm0", csr_group.mhpmcounter[0], m_hpm[0]);
    chk("grp_hpm1", csr_group.mhpmcounter[1], m_hpm[1]);
    chk("grp_mip", csr_group.mip, m_mip());
    chk("grp_mode", 64'(csr_group.mode), 64'(m_mode));
  endtask

  task automatic step(input logic [11:0] a);
    model_step();
    @(posedge clk);
    #1;
    check_all(a);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [1:0] op, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_op = op; wr_data = d;
    step(a);
    wr_en = 1'b0;
  endtask

  logic [11:0] addr_tab [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB03, 12'hB04,
                                 12'hB05, 12'hF14, 12'h7C0, 12'h305};

  initial begin
    reset = 1'b0; rd_addr = 12'h305; wr_en = 1'b0; wr_op = 2'b00; wr_addr = '0; wr_data = '0;
    trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret_req = 1'b0;
    instret = 1'b0; hpm_event = '0; irq_timer = 1'b0; irq_ext = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(12'h305);
    chk("rst_mtvec", rd_data, MTVEC_RST);
    chk("rst_mode", 64'(csr_group.mode), 64'd3);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    reset = 1'b1;

    // mcycle counts from the first edge after release
    for (int i = 0; i < 10; i++) step(12'hB00);
    chk("mcycle_10", rd_data, 64'd10);
    check_all(12'h7C0);
    chk("illegal_flag", 64'(rd_illegal), 64'd1);
    chk("illegal_data", rd_data, 64'd0);

    // Write / set / clear
    do_write(12'h340, 2'b00, 64'hF0);
    do_write(12'h340, 2'b01, 64'h0F);
    do_write(12'h340, 2'b10, 64'h30);
    check_all(12'h340);
    chk("mscratch_rmw", rd_data, 64'hCF);

    // Vectored interrupt trap
    do_write(12'h300, 2'b01, 64'h8);
    do_write(12'h305, 2'b00, 64'h1001);
    trap_req = 1'b1; trap_cause = 64'h8000_0000_0000_0007; trap_pc = 64'h2000; trap_tval = 64'h55;
    step(12'h341);
    trap_req = 1'b0;
    chk("trap_valid", 64'(redirect_valid), 64'd1);
    chk("trap_pc", redirect_pc, 64'h101C);
    chk("trap_mepc", csr_group.mepc, 64'h2000);
    chk("trap_mie", 64'(csr_group.mstatus[3]), 64'd0);
    chk("trap_mpie", 64'(csr_group.mstatus[7]), 64'd1);
    step(12'h300);
    chk("trap_done", 64'(redirect_valid), 64'd0);

    // mret back
    mret_req = 1'b1;
    step(12'h300);
    mret_req = 1'b0;
    chk("ret_pc", redirect_pc, 64'h2000);
    chk("ret_mie", 64'(csr_group.mstatus[3]), 64'd1);
    chk("ret_mode", 64'(csr_group.mode), 64'd3);
    step(12'h300);

    // trap beats mret and a write in the same cycle
    trap_req = 1'b1; mret_req = 1'b1; trap_cause = 64'h2; trap_pc = 64'h3004;
    wr_en = 1'b1; wr_op = 2'b00; wr_addr = 12'h340; wr_data = 64'h1234;
    step(12'h340);
    trap_req = 1'b0; mret_req = 1'b0; wr_en = 1'b0;
    chk("prio_mscratch", rd_data, 64'hCF);
    chk("prio_pc", redirect_pc, 64'h1000);
    step(12'h340);

    // minstret wrap
    do_write(12'hB02, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
    instret = 1'b1;
    step(12'hB02);
    instret = 1'b0;
    chk("minstret_wrap", rd_data, 64'd0);

    // Reset during TRAP clears redirect without an edge
    trap_req = 1'b1; trap_cause = 64'h5; trap_pc = 64'h4000;
    step(12'h300);
    trap_req = 1'b0;
    chk("pre_rst_valid", 64'(redirect_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_valid", 64'(redirect_valid), 64'd0);
    chk("async_pc", redirect_pc, 64'd0);
    model_reset();
    step(12'h305);
    reset = 1'b1;

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_op      = 2'($urandom_range(0, 3));
      wr_addr    = addr_tab[$urandom_range(0, 15)];
      wr_data    = {$urandom, $urandom};
      trap_req   = ($urandom_range(0, 15) == 0);
      mret_req   = ($urandom_range(0, 15) == 0);
      trap_cause = {1'($urandom_range(0, 1)), 59'd0, 4'($urandom_range(0, 15))};
      trap_pc    = {$urandom, $urandom};
      trap_tval  = {$urandom, $urandom};
      instret    = 1'($urandom_range(0, 1));
      hpm_event  = 2'($urandom_range(0, 3));
      irq_timer  = 1'($urandom_range(0, 1));
      irq_ext    = 1'($urandom_range(0, 1));
      step(addr_tab[$urandom_range(0, 15)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
